// File: rtl/wb_arbiter.sv
// Two-master Wishbone pipelined arbiter with alternating tie-break, outstanding
// request tracking, and a response timeout that aborts a hung slave transaction.
//
// state | meaning
// IDLE  | no owner; arbitrate among masters asserting cyc
// OWN0  | master 0 owns the shared bus, pass-through
// OWN1  | master 1 owns the shared bus, pass-through
// ABORT | timeout fired; wait for the owner to drop cyc
module wb_arbiter #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned AW      = 30
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_m0_cyc,
   input  logic          i_m0_stb,
   input  logic          i_m0_we,
   input  logic [AW-1:0] i_m0_addr,
   input  logic [31:0]   i_m0_data,
   input  logic [3:0]    i_m0_sel,
   output logic          o_m0_stall,
   output logic          o_m0_ack,
   output logic          o_m0_err,
   output logic [31:0]   o_m0_data,
   input  logic          i_m1_cyc,
   input  logic          i_m1_stb,
   input  logic          i_m1_we,
   input  logic [AW-1:0] i_m1_addr,
   input  logic [31:0]   i_m1_data,
   input  logic [3:0]    i_m1_sel,
   output logic          o_m1_stall,
   output logic          o_m1_ack,
   output logic          o_m1_err,
   output logic [31:0]   o_m1_data,
   output logic          o_wb_cyc,
   output logic          o_wb_stb,
   output logic          o_wb_we,
   output logic [AW-1:0] o_wb_addr,
   output logic [31:0]   o_wb_data,
   output logic [3:0]    o_wb_sel,
   input  logic          i_wb_stall,
   input  logic          i_wb_ack,
   input  logic          i_wb_err,
   input  logic [31:0]   i_wb_data,
   output logic [1:0]    o_grant,
   output logic          o_timeout
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN0  = 2'd1,
      OWN1  = 2'd2,
      ABORT = 2'd3
   } state_e;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_e        state_q, state_d;
   logic          last_owner_q, last_owner_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [7:0]    timer_q, timer_d;

   logic          owned;
   logic          resp;
   logic          full;
   logic          accept;
   logic          timeout_fire;
   logic          sel_cyc, sel_stb, sel_we;
   logic [AW-1:0] sel_addr;
   logic [31:0]   sel_data;
   logic [3:0]    sel_sel;

   assign owned  = (state_q == OWN0) || (state_q == OWN1);
   assign resp   = i_wb_ack | i_wb_err;
   assign full   = (cnt_q == 4'hF);
   assign accept = o_wb_stb & ~i_wb_stall;

   // Fires on the cycle the timer would reach TIMEOUT with no response in sight.
   assign timeout_fire = owned && !i_reset && (cnt_q != 4'd0) && !resp
                         && (timer_q == TMO_LAST);

   assign o_grant   = {state_q == OWN1, state_q == OWN0};
   assign o_timeout = timeout_fire;

   always_comb begin
      if (state_q == OWN1) begin
         sel_cyc  = i_m1_cyc;
         sel_stb  = i_m1_stb;
         sel_we   = i_m1_we;
         sel_addr = i_m1_addr;
         sel_data = i_m1_data;
         sel_sel  = i_m1_sel;
      end else begin
         sel_cyc  = i_m0_cyc;
         sel_stb  = i_m0_stb;
         sel_we   = i_m0_we;
         sel_addr = i_m0_addr;
         sel_data = i_m0_data;
         sel_sel  = i_m0_sel;
      end
   end

   always_comb begin
      o_wb_cyc  = 1'b0;
      o_wb_stb  = 1'b0;
      o_wb_we   = 1'b0;
      o_wb_addr = '0;
      o_wb_data = '0;
      o_wb_sel  = '0;
      if (owned) begin
         o_wb_cyc  = sel_cyc & ~timeout_fire;
         // A full counter blocks new strobes so the slave never sees a 16th request.
         o_wb_stb  = sel_stb & ~full & ~timeout_fire;
         o_wb_we   = sel_we;
         o_wb_addr = sel_addr;
         o_wb_data = sel_data;
         o_wb_sel  = sel_sel;
      end
   end

   always_comb begin
      o_m0_stall = 1'b1;
      o_m0_ack   = 1'b0;
      o_m0_err   = 1'b0;
      o_m0_data  = '0;
      o_m1_stall = 1'b1;
      o_m1_ack   = 1'b0;
      o_m1_err   = 1'b0;
      o_m1_data  = '0;
      if (state_q == OWN0) begin
         o_m0_stall = i_wb_stall | full;
         o_m0_ack   = i_wb_ack;
         o_m0_err   = i_wb_err | timeout_fire;
         o_m0_data  = i_wb_data;
      end else if (state_q == OWN1) begin
         o_m1_stall = i_wb_stall | full;
         o_m1_ack   = i_wb_ack;
         o_m1_err   = i_wb_err | timeout_fire;
         o_m1_data  = i_wb_data;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      cnt_d        = cnt_q;
      timer_d      = timer_q;

      unique case (state_q)
         IDLE: begin
            if (i_m0_cyc && i_m1_cyc)
               state_d = last_owner_q ? OWN0 : OWN1;
            else if (i_m0_cyc)
               state_d = OWN0;
            else if (i_m1_cyc)
               state_d = OWN1;
         end
         OWN0, OWN1: begin
            if (timeout_fire)
               state_d = ABORT;
            else if (!sel_cyc)
               state_d = IDLE;
         end
         ABORT: begin
            // last_owner still names the master that was aborted.
            if (!(last_owner_q ? i_m1_cyc : i_m0_cyc))
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (state_q == IDLE && state_d == OWN0)
         last_owner_d = 1'b0;
      else if (state_q == IDLE && state_d == OWN1)
         last_owner_d = 1'b1;

      if (owned && state_d == state_q) begin
         if (accept && !(resp && cnt_q != 4'd0))
            cnt_d = cnt_q + 4'd1;
         else if (!accept && resp && cnt_q != 4'd0)
            cnt_d = cnt_q - 4'd1;
      end else begin
         cnt_d = 4'd0;
      end

      if (!owned || state_d != state_q || resp || cnt_q == 4'd0)
         timer_d = 8'd0;
      else
         timer_d = timer_q + 8'd1;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q      <= IDLE;
         last_owner_q <= 1'b1;
         cnt_q        <= 4'd0;
         timer_q      <= 8'd0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         cnt_q        <= cnt_d;
         timer_q      <= timer_d;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with TIMEOUT=4: arbitration, pass-through,
// outstanding counting, timeout abort, reset and abandon behaviour.
module tb_wb_arbiter;

   localparam int AW = 30;

   logic          i_clk;
   logic          i_reset;
   logic          i_m0_cyc, i_m0_stb, i_m0_we;
   logic [AW-1:0] i_m0_addr;
   logic [31:0]   i_m0_data;
   logic [3:0]    i_m0_sel;
   logic          o_m0_stall, o_m0_ack, o_m0_err;
   logic [31:0]   o_m0_data;
   logic          i_m1_cyc, i_m1_stb, i_m1_we;
   logic [AW-1:0] i_m1_addr;
   logic [31:0]   i_m1_data;
   logic [3:0]    i_m1_sel;
   logic          o_m1_stall, o_m1_ack, o_m1_err;
   logic [31:0]   o_m1_data;
   logic          o_wb_cyc, o_wb_stb, o_wb_we;
   logic [AW-1:0] o_wb_addr;
   logic [31:0]   o_wb_data;
   logic [3:0]    o_wb_sel;
   logic          i_wb_stall, i_wb_ack, i_wb_err;
   logic [31:0]   i_wb_data;
   logic [1:0]    o_grant;
   logic          o_timeout;

   int n_checks = 0;
   int n_fail   = 0;

   wb_arbiter #(.TIMEOUT(4), .AW(AW)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_m0_cyc(i_m0_cyc), .i_m0_stb(i_m0_stb), .i_m0_we(i_m0_we),
      .i_m0_addr(i_m0_addr), .i_m0_data(i_m0_data), .i_m0_sel(i_m0_sel),
      .o_m0_stall(o_m0_stall), .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err),
      .o_m0_data(o_m0_data),
      .i_m1_cyc(i_m1_cyc), .i_m1_stb(i_m1_stb), .i_m1_we(i_m1_we),
      .i_m1_addr(i_m1_addr), .i_m1_data(i_m1_data), .i_m1_sel(i_m1_sel),
      .o_m1_stall(o_m1_stall), .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err),
      .o_m1_data(o_m1_data),
      .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
      .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
      .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
      .i_wb_data(i_wb_data),
      .o_grant(o_grant), .o_timeout(o_timeout)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      i_reset = 1'b1;
      i_m0_cyc = 0; i_m0_stb = 0; i_m0_we = 0; i_m0_addr = '0; i_m0_data = '0; i_m0_sel = '0;
      i_m1_cyc = 0; i_m1_stb = 0; i_m1_we = 0; i_m1_addr = '0; i_m1_data = '0; i_m1_sel = '0;
      i_wb_stall = 0; i_wb_ack = 0; i_wb_err = 0; i_wb_data = '0;
      tick();
      tick();
      #1;
      check_eq("rst_grant",    64'(o_grant),    64'h0);
      check_eq("rst_wb_cyc",   64'(o_wb_cyc),   64'h0);
      check_eq("rst_wb_addr",  64'(o_wb_addr),  64'h0);
      check_eq("rst_m0_stall", 64'(o_m0_stall), 64'h1);
      check_eq("rst_m1_stall", 64'(o_m1_stall), 64'h1);
      check_eq("rst_m0_ack",   64'(o_m0_ack),   64'h0);
      check_eq("rst_timeout",  64'(o_timeout),  64'h0);
      i_reset = 1'b0;

      // single write from m0
      i_m0_cyc = 1; i_m0_stb = 1; i_m0_we = 1; i_m0_addr = 30'h10;
      i_m0_data = 32'hA5A5_A5A5; i_m0_sel = 4'hF;
      #1;
      check_eq("wr_idle_grant", 64'(o_grant),    64'h0);
      check_eq("wr_idle_stall", 64'(o_m0_stall), 64'h1);
      tick();
      #1;
      check_eq("wr_grant",    64'(o_grant),    64'h1);
      check_eq("wr_wb_cyc",   64'(o_wb_cyc),   64'h1);
      check_eq("wr_wb_stb",   64'(o_wb_stb),   64'h1);
      check_eq("wr_wb_we",    64'(o_wb_we),    64'h1);
      check_eq("wr_wb_addr",  64'(o_wb_addr),  64'h10);
      check_eq("wr_wb_data",  64'(o_wb_data),  64'hA5A5_A5A5);
      check_eq("wr_wb_sel",   64'(o_wb_sel),   64'hF);
      check_eq("wr_m0_stall", 64'(o_m0_stall), 64'h0);
      check_eq("wr_m1_stall", 64'(o_m1_stall), 64'h1);
      tick();
      i_m0_stb = 0; i_m0_we = 0; i_wb_ack = 1; i_wb_data = 32'h1234_5678;
      #1;
      check_eq("wr_m0_ack",  64'(o_m0_ack),  64'h1);
      check_eq("wr_m0_data", 64'(o_m0_data), 64'h1234_5678);
      check_eq("wr_m1_ack",  64'(o_m1_ack),  64'h0);
      check_eq("wr_m1_data", 64'(o_m1_data), 64'h0);
      check_eq("wr_cnt1",    64'(dut.cnt_q), 64'h1);
      tick();
      i_wb_ack = 0; i_m0_cyc = 0;
      #1;
      check_eq("wr_cnt0", 64'(dut.cnt_q), 64'h0);
      tick();
      #1;
      check_eq("wr_end_grant", 64'(o_grant),   64'h0);
      check_eq("wr_idle_addr", 64'(o_wb_addr), 64'h0);

      // tie alternation after reset, plus a stray ack with nothing outstanding
      i_reset = 1;
      tick();
      i_reset = 0; i_m0_cyc = 1; i_m1_cyc = 1;
      tick();
      #1;
      check_eq("tie1_grant",    64'(o_grant),    64'h1);
      check_eq("tie1_m1_stall", 64'(o_m1_stall), 64'h1);
      i_wb_ack = 1; i_m0_cyc = 0;
      #1;
      check_eq("ack_cnt0_pass", 64'(o_m0_ack), 64'h1);
      tick();
      i_wb_ack = 0;
      #1;
      check_eq("tie_idle_gap", 64'(o_grant),   64'h0);
      check_eq("ack_cnt0_sat", 64'(dut.cnt_q), 64'h0);
      tick();
      #1;
      check_eq("tie2_grant", 64'(o_grant), 64'h2);
      i_m1_cyc = 0;
      tick();
      i_m0_cyc = 1; i_m1_cyc = 1;
      tick();
      #1;
      check_eq("tie3_grant", 64'(o_grant), 64'h1);
      i_m0_cyc = 0; i_m1_cyc = 0;
      tick();

      // three pipelined reads: two stall cycles, then three acks
      i_m0_cyc = 1; i_m0_stb = 1; i_m0_addr = 30'h20; i_wb_stall = 1;
      tick();
      i_m1_cyc = 1;
      #1;
      check_eq("rd_cnt_c1",    64'(dut.cnt_q),  64'h0);
      check_eq("rd_stall_c1",  64'(o_m0_stall), 64'h1);
      check_eq("rd_grant_c1",  64'(o_grant),    64'h1);
      tick();
      #1;
      check_eq("rd_cnt_c2", 64'(dut.cnt_q), 64'h0);
      tick();
      i_wb_stall = 0;
      #1;
      check_eq("rd_cnt_c3",   64'(dut.cnt_q),  64'h0);
      check_eq("rd_stall_c3", 64'(o_m0_stall), 64'h0);
      tick();
      i_m0_addr = 30'h21;
      #1;
      check_eq("rd_cnt_c4", 64'(dut.cnt_q), 64'h1);
      tick();
      i_m0_addr = 30'h22;
      #1;
      check_eq("rd_cnt_c5",   64'(dut.cnt_q), 64'h2);
      check_eq("rd_no_preempt", 64'(o_grant), 64'h1);
      for (int k = 0; k < 3; k++) begin
         tick();
         i_m0_stb = 0; i_wb_ack = 1; i_wb_data = 32'hD000_0000 + 32'(k);
         #1;
         check_eq("rd_ack_cnt",  64'(dut.cnt_q),  64'(3 - k));
         check_eq("rd_m0_ack",   64'(o_m0_ack),   64'h1);
         check_eq("rd_m0_data",  64'(o_m0_data),  64'hD000_0000 + 64'(k));
         check_eq("rd_m1_ack",   64'(o_m1_ack),   64'h0);
         check_eq("rd_m1_data",  64'(o_m1_data),  64'h0);
      end
      tick();
      i_wb_ack = 0;
      #1;
      check_eq("rd_cnt_end", 64'(dut.cnt_q), 64'h0);
      i_m0_cyc = 0;
      tick();
      #1;
      check_eq("rd_idle_gap", 64'(o_grant), 64'h0);
      tick();
      #1;
      check_eq("rd_m1_grant", 64'(o_grant), 64'h2);
      i_m1_cyc = 0;
      tick();

      // timeout abort: one request, slave never answers
      i_m0_cyc = 1; i_m0_stb = 1; i_m0_addr = 30'h30;
      tick();
      tick();
      i_m0_stb = 0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check_eq("tmo_early_pulse", 64'(o_timeout), 64'h0);
         check_eq("tmo_early_err",   64'(o_m0_err),  64'h0);
         tick();
      end
      #1;
      check_eq("tmo_m0_err",  64'(o_m0_err),  64'h1);
      check_eq("tmo_pulse",   64'(o_timeout), 64'h1);
      check_eq("tmo_wb_cyc",  64'(o_wb_cyc),  64'h0);
      check_eq("tmo_m1_err",  64'(o_m1_err),  64'h0);
      tick();
      i_wb_ack = 1;
      #1;
      check_eq("abort_grant",   64'(o_grant),    64'h0);
      check_eq("abort_ack_ign", 64'(o_m0_ack),   64'h0);
      check_eq("abort_pulse",   64'(o_timeout),  64'h0);
      check_eq("abort_stall",   64'(o_m0_stall), 64'h1);
      check_eq("abort_cnt",     64'(dut.cnt_q),  64'h0);
      i_wb_ack = 0; i_m1_cyc = 1;
      tick();
      #1;
      check_eq("abort_hold1", 64'(o_grant), 64'h0);
      tick();
      #1;
      check_eq("abort_hold2", 64'(o_grant), 64'h0);
      i_m0_cyc = 0;
      tick();
      #1;
      check_eq("abort_idle", 64'(o_grant), 64'h0);
      tick();
      #1;
      check_eq("abort_next_m1", 64'(o_grant), 64'h2);
      i_m1_cyc = 0;
      tick();

      // reset in the middle of a burst with two outstanding
      i_m0_cyc = 1; i_m0_stb = 1; i_m0_addr = 30'h40;
      tick();
      tick();
      #1;
      check_eq("rb_cnt1", 64'(dut.cnt_q), 64'h1);
      tick();
      i_m0_stb = 0;
      #1;
      check_eq("rb_cnt2", 64'(dut.cnt_q), 64'h2);
      i_reset = 1; i_m1_cyc = 1;
      tick();
      i_reset = 0; i_wb_ack = 1;
      #1;
      check_eq("rb_wb_cyc", 64'(o_wb_cyc), 64'h0);
      check_eq("rb_grant",  64'(o_grant),  64'h0);
      check_eq("rb_m0_ack", 64'(o_m0_ack), 64'h0);
      check_eq("rb_m0_err", 64'(o_m0_err), 64'h0);
      check_eq("rb_m1_ack", 64'(o_m1_ack), 64'h0);
      check_eq("rb_m1_err", 64'(o_m1_err), 64'h0);
      check_eq("rb_cnt",    64'(dut.cnt_q), 64'h0);
      i_wb_ack = 0;
      tick();
      #1;
      check_eq("rb_tie_m0", 64'(o_grant), 64'h1);
      i_m0_cyc = 0;
      tick();
      tick();
      i_m1_cyc = 0;
      tick();

      // owner abandons with one outstanding; late ack must vanish
      i_m0_cyc = 1; i_m0_stb = 1; i_m0_addr = 30'h50;
      tick();
      i_m1_cyc = 1;
      tick();
      i_m0_stb = 0; i_m0_cyc = 0;
      #1;
      check_eq("ab_cnt1",  64'(dut.cnt_q), 64'h1);
      check_eq("ab_grant", 64'(o_grant),   64'h1);
      tick();
      i_wb_ack = 1; i_wb_data = 32'hDEAD_BEEF;
      #1;
      check_eq("ab_late_m0_ack",  64'(o_m0_ack),  64'h0);
      check_eq("ab_late_m1_ack",  64'(o_m1_ack),  64'h0);
      check_eq("ab_late_m1_data", 64'(o_m1_data), 64'h0);
      check_eq("ab_idle_grant",   64'(o_grant),   64'h0);
      check_eq("ab_cnt0",         64'(dut.cnt_q), 64'h0);
      tick();
      i_wb_ack = 0;
      #1;
      check_eq("ab_m1_grant", 64'(o_grant), 64'h2);
      i_m1_cyc = 0;
      tick();

      // fill the outstanding counter to 15, acking every third cycle
      i_m0_cyc = 1; i_m0_stb = 1; i_m0_addr = 30'h60;
      tick();
      for (int i = 0; i < 22; i++) begin
         i_wb_ack = ((i % 3) == 2);
         tick();
      end
      i_wb_ack = 0;
      #1;
      check_eq("full_cnt15", 64'(dut.cnt_q),  64'hF);
      check_eq("full_stall", 64'(o_m0_stall), 64'h1);
      check_eq("full_nostb", 64'(o_wb_stb),   64'h0);
      check_eq("full_notmo", 64'(o_timeout),  64'h0);
      tick();
      i_wb_ack = 1;
      #1;
      check_eq("full_stall_ack", 64'(o_m0_stall), 64'h1);
      check_eq("full_ack",       64'(o_m0_ack),   64'h1);
      tick();
      i_wb_ack = 0; i_m0_stb = 0;
      #1;
      check_eq("full_cnt14",   64'(dut.cnt_q),  64'hE);
      check_eq("full_release", 64'(o_m0_stall), 64'h0);
      i_m0_cyc = 0;
      tick();
      #1;
      check_eq("full_drop_grant", 64'(o_grant),   64'h0);
      check_eq("full_drop_cnt",   64'(dut.cnt_q), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, cycles without ack/err on an outstanding request before the arbiter aborts; legal range 2..255.
REQ-002 Parameter AW, default 30, Wishbone word-address width.
REQ-003 i_clk  in  1  sole clock; all logic on rising edge.
REQ-004 i_reset  in  1  reset; synchronous, active-high, one clock.
REQ-005 i_mN_cyc, i_mN_stb, i_mN_we  in  1 each (N=0,1)  master N cycle, strobe, write enable.
REQ-006 i_mN_addr  in  AW; i_mN_data  in  32; i_mN_sel  in  4  master N address, write data, byte selects.
REQ-007 o_mN_stall, o_mN_ack, o_mN_err  out  1 each; o_mN_data  out  32  returns to master N.
REQ-008 o_wb_cyc, o_wb_stb, o_wb_we  out  1; o_wb_addr  out  AW; o_wb_data  out  32; o_wb_sel  out  4  shared slave bus.
REQ-009 i_wb_stall, i_wb_ack, i_wb_err  in  1; i_wb_data  in  32  slave returns.
REQ-010 o_grant  out  2  one-hot current owner (bit N = master N), 2'b00 when idle/abort.
REQ-011 o_timeout  out  1  one-cycle pulse when a timeout abort fires.

Function
REQ-012 FSM states IDLE, OWN0, OWN1, ABORT; registered; o_grant decoded from state.
REQ-013 IDLE: only m0 cyc -> OWN0; only m1 cyc -> OWN1; both -> master not equal to last_owner register; neither -> stay.
REQ-014 last_owner updates on entry to OWNn; reset value 1 so m0 wins the first tie.
REQ-015 OWNn: bus outputs = master n inputs combinationally; o_wb_cyc = i_mn_cyc; o_mn_stall/ack/err/data = slave inputs.
REQ-016 Non-owner and all masters in IDLE/ABORT: stall=1, ack=0, err=0, data=0.
REQ-017 IDLE/ABORT bus outputs: cyc=0, stb=0, we=0, addr/data/sel=0.
REQ-018 No preemption: OWNn held until i_mn_cyc=0 sampled; then -> IDLE; minimum one IDLE cycle between owners.
REQ-019 Outstanding counter, 4 bits: +1 on o_wb_stb & ~i_wb_stall, -1 on i_wb_ack|i_wb_err, both same cycle -> unchanged; cleared on leaving OWNn.
REQ-020 Counter at 15: owner stall forced 1 (no further accepts) until a response decrements it.
REQ-021 Ack/err with counter 0 passed to owner unchanged, counter not decremented (saturate at 0).
REQ-022 Timer, 8 bits: cleared on ack/err, on counter=0 and on state change; increments each OWNn cycle with counter>0 and no ack/err.
REQ-023 Timer reaches TIMEOUT: same cycle o_mn_err=1 to owner, o_timeout=1, o_wb_cyc forced 0; next state ABORT.
REQ-024 ABORT: stay until owner i_mn_cyc=0, then IDLE; slave responses ignored; counter and timer cleared.
REQ-025 Master dropping cyc with counter>0: legal (abandon); -> IDLE, counter cleared, late slave acks discarded.
REQ-026 Single pass-through combinational path only; no added latency on stb/ack beyond grant acquisition (grant visible cycle after first cyc sample).

Reset
REQ-027 On i_reset: state IDLE, last_owner=1, counter=0, timer=0, o_timeout=0; all bus outputs 0; all master stall=1, ack/err=0, data=0.
REQ-028 Reset mid-transaction drops o_wb_cyc in the cycle after reset sampled; no err generated to masters.
REQ-029 Post-reset, arbitration restarts from IDLE regardless of master cyc levels.

Verification
REQ-030 m0 cyc alone, 1 write addr 0x10 data 0xA5A5A5A5, slave ack 1 cycle later -> o_grant=01 one cycle after cyc, bus shows 0x10/0xA5A5A5A5, o_m0_ack=1, m1 stall=1.
REQ-031 m0 and m1 cyc rise same cycle after reset -> o_grant=01 first; m0 drops cyc -> 1 IDLE cycle -> o_grant=10; repeat tie -> 01 (alternates).
REQ-032 Owner issues 3 pipelined reads, slave stalls 2 cycles then acks 3 -> counter 0,1,2,3,2,1,0; all 3 acks and data reach owner only.
REQ-033 TIMEOUT=4, owner 1 request, slave never acks -> 4th cycle without ack: o_m0_err=1, o_timeout=1, o_wb_cyc=0; ABORT until m0 cyc low, then IDLE.
REQ-034 i_reset asserted mid-burst with counter=2 -> next cycle o_wb_cyc=0, o_grant=00, no ack/err to either master; later tie grants m0.
REQ-035 Owner drops cyc with 1 outstanding, slave acks next cycle -> ack not delivered to either master, counter 0, other pending master granted after 1 IDLE cycle.
